// File: rtl/prach_buffer_mch.sv
// prach_buffer_mch: multi-channel ping-pong PRACH capture buffer.
// Descriptor arms a channel; samples fill a bank; full banks queue to ap_req.
module prach_buffer_mch #(
  parameter int NUM_CH  = 4,
  parameter int SYM_LEN = 1536,
  parameter int MAX_SYM = 4,
  parameter int CH_W    = 8,
  parameter int ADDR_W  = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  din_valid,
  input  logic [15:0]           din_dr,
  input  logic [15:0]           din_di,
  input  logic [CH_W-1:0]       din_chn,
  input  logic [15:0]           din_sample_k,
  input  logic                  c_valid,
  output logic                  c_ready,
  input  logic [CH_W-1:0]       c_chn,
  input  logic [119:0]          c_header,
  input  logic [19:0]           c_time_offset,
  input  logic [3:0]            c_num_symbol,
  output logic [NUM_CH-1:0]     ap_req,
  input  logic [NUM_CH-1:0]     ap_ack,
  output logic [120*NUM_CH-1:0] ap_hdr,
  output logic [NUM_CH-1:0]     ap_bank,
  output logic [16*NUM_CH-1:0]  ap_len,
  input  logic [CH_W-1:0]       rd_ch,
  input  logic                  rd_bank,
  input  logic [ADDR_W-1:0]     rd_addr,
  input  logic                  rd_en,
  output logic [31:0]           rd_data,
  output logic                  err_cmd
);

  localparam int DEPTH = SYM_LEN * MAX_SYM;
  localparam int MEM_D = NUM_CH * 2 * DEPTH;
  localparam int MW    = $clog2(MEM_D);
  localparam int CI_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAP
  } state_t;

  state_t       st_q   [NUM_CH];
  state_t       st_d   [NUM_CH];
  logic [15:0]  cnt_q  [NUM_CH];
  logic [15:0]  cnt_d  [NUM_CH];
  logic [15:0]  off_q  [NUM_CH];
  logic [15:0]  len_q  [NUM_CH];
  logic         cur_q  [NUM_CH];
  logic [1:0]   busy_q [NUM_CH];
  logic [119:0] bhdr_q [NUM_CH][2];
  logic [15:0]  blen_q [NUM_CH][2];
  logic         q0_q   [NUM_CH];
  logic         q1_q   [NUM_CH];
  logic         q0_d   [NUM_CH];
  logic         q1_d   [NUM_CH];
  logic [1:0]   qn_q   [NUM_CH];
  logic [1:0]   qn_d   [NUM_CH];

  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] fin;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] load;
  logic [NUM_CH-1:0] req_d;

  logic [CI_W-1:0] ci;
  logic            c_bad_ch;
  logic            c_bad;
  logic            acc;
  logic            acc_ok;
  logic            tgt;
  logic [15:0]     c_len;

  logic          wr_en_d;
  logic [MW-1:0] wr_idx_d;
  logic          wr_en_q;
  logic [MW-1:0] wr_idx_q;
  logic [31:0]   wr_data_q;

  logic [31:0]   mem [MEM_D];
  logic [MW-1:0] rd_idx;
  logic [MW-1:0] rd_idx_q;
  logic [31:0]   mem_q;
  logic          rd_v1;
  logic          rd_v2;

  function automatic logic [MW-1:0] base(input int ch, input logic b);
    return MW'(ch * 2 * DEPTH + (b ? DEPTH : 0));
  endfunction

  // Descriptor decode: readiness comes from registered channel/bank state.
  always_comb begin
    ci       = c_chn[CI_W-1:0];
    c_bad_ch = (c_chn >= CH_W'(NUM_CH));
    c_bad    = c_bad_ch || (c_num_symbol == 4'd0) ||
               (c_num_symbol > 4'(MAX_SYM));
    c_ready  = !rst && (c_bad_ch ||
               ((st_q[ci] == S_IDLE) && (busy_q[ci] != 2'b11)));
    acc      = c_valid && c_ready;
    acc_ok   = acc && !c_bad;
    tgt      = busy_q[ci][0];
    c_len    = 16'(SYM_LEN) * {12'd0, c_num_symbol};
    rd_idx   = MW'(rd_ch) * MW'(2 * DEPTH) +
               (rd_bank ? MW'(DEPTH) : '0) + MW'(rd_addr);
  end

  // Per-channel sample strobe.
  always_comb begin
    hit = '0;
    for (int ch = 0; ch < NUM_CH; ch++)
      hit[ch] = din_valid && (din_chn == CH_W'(ch));
  end

  // Capture FSM next state and write-port request.
  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    fin      = '0;
    wr_en_d  = 1'b0;
    wr_idx_d = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      unique case (st_q[ch])
        S_IDLE: begin
          if (acc_ok && (ci == CI_W'(ch)))
            st_d[ch] = S_ARMED;
        end
        S_ARMED: begin
          if (hit[ch] && (din_sample_k == off_q[ch])) begin
            st_d[ch]  = S_CAP;
            cnt_d[ch] = 16'd1;
            wr_en_d   = 1'b1;
            wr_idx_d  = base(ch, cur_q[ch]);
          end
        end
        S_CAP: begin
          if (hit[ch]) begin
            wr_en_d  = 1'b1;
            wr_idx_d = base(ch, cur_q[ch]) + MW'(cnt_q[ch]);
            if (cnt_q[ch] == len_q[ch] - 16'd1) begin
              fin[ch]   = 1'b1;
              cnt_d[ch] = '0;
              st_d[ch]  = S_IDLE;
            end else begin
              cnt_d[ch] = cnt_q[ch] + 16'd1;
            end
          end
        end
        default: st_d[ch] = S_IDLE;
      endcase
    end
  end

  // Full-bank queue: pop on ack, push on final write, present head.
  always_comb begin
    q0_d  = q0_q;
    q1_d  = q1_q;
    qn_d  = qn_q;
    pop   = '0;
    load  = '0;
    req_d = ap_req;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      pop[ch] = ap_req[ch] && ap_ack[ch];
      if (pop[ch]) begin
        q0_d[ch] = q1_q[ch];
        qn_d[ch] = qn_q[ch] - 2'd1;
      end
      if (fin[ch]) begin
        if (qn_d[ch] == 2'd0)
          q0_d[ch] = cur_q[ch];
        else
          q1_d[ch] = cur_q[ch];
        qn_d[ch] = qn_d[ch] + 2'd1;
      end
      if (pop[ch]) begin
        req_d[ch] = 1'b0;
      end else if (!ap_req[ch] && (qn_d[ch] != 2'd0)) begin
        req_d[ch] = 1'b1;
        load[ch]  = 1'b1;
      end
    end
  end

  // Channel state, bank bookkeeping and request outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        st_q[ch]   <= S_IDLE;
        cnt_q[ch]  <= '0;
        busy_q[ch] <= '0;
        q0_q[ch]   <= 1'b0;
        q1_q[ch]   <= 1'b0;
        qn_q[ch]   <= '0;
      end
      ap_req  <= '0;
      ap_hdr  <= '0;
      ap_bank <= '0;
      ap_len  <= '0;
      err_cmd <= 1'b0;
      wr_en_q <= 1'b0;
    end else begin
      err_cmd <= acc && c_bad;
      wr_en_q <= wr_en_d;
      ap_req  <= req_d;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        st_q[ch]  <= st_d[ch];
        cnt_q[ch] <= cnt_d[ch];
        q0_q[ch]  <= q0_d[ch];
        q1_q[ch]  <= q1_d[ch];
        qn_q[ch]  <= qn_d[ch];
        if (pop[ch])
          busy_q[ch][q0_q[ch]] <= 1'b0;
        if (acc_ok && (ci == CI_W'(ch))) begin
          busy_q[ch][tgt]  <= 1'b1;
          cur_q[ch]        <= tgt;
          off_q[ch]        <= c_time_offset[19:4];
          len_q[ch]        <= c_len;
          bhdr_q[ch][tgt]  <= c_header;
          blen_q[ch][tgt]  <= c_len;
        end
        if (load[ch]) begin
          ap_hdr[120*ch +: 120] <= bhdr_q[ch][q0_d[ch]];
          ap_bank[ch]           <= q0_d[ch];
          ap_len[16*ch +: 16]   <= blen_q[ch][q0_d[ch]];
        end
      end
    end
  end

  // Registered write port and memory array.
  always_ff @(posedge clk) begin
    wr_idx_q  <= wr_idx_d;
    wr_data_q <= {din_di, din_dr};
    if (wr_en_q)
      mem[wr_idx_q] <= wr_data_q;
    rd_idx_q <= rd_idx;
    mem_q    <= mem[rd_idx_q];
  end

  // Read valid pipeline; idle cycles return zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_v1   <= 1'b0;
      rd_v2   <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_v1   <= rd_en;
      rd_v2   <= rd_v1;
      rd_data <= rd_v2 ? mem_q : 32'd0;
    end
  end

endmodule

// File: doc/prach_buffer_mch.md
Name: prach_buffer_mch

Overview:
- Multi-channel, double-banked PRACH capture buffer for the PRACH long-format path.
- Accepts time-interleaved IQ samples for NUM_CH antenna channels and single-clock C-Plane capture descriptors.
- Captures SYM_LEN*num_symbol samples per occasion into a per-channel ping-pong bank, then raises a per-channel request to the downstream processor.
- Capture of the next occasion proceeds while the previous bank is read out.

Parameters:
NUM_CH, 4, number of interleaved channels; din_chn/c_chn/rd_ch values 0..NUM_CH-1
SYM_LEN, 1536, samples per PRACH symbol
MAX_SYM, 4, max symbols per occasion; bank depth = SYM_LEN*MAX_SYM words
CH_W, 8, width of channel index ports
ADDR_W, 13, read address width; must be >= clog2(SYM_LEN*MAX_SYM)

Ports:
clk  in  1  clock for all logic
rst  in  1  synchronous reset, active-high
din_valid  in  1  sample strobe
din_dr  in  16  sample real part
din_di  in  16  sample imaginary part
din_chn  in  CH_W  channel of current sample
din_sample_k  in  16  sample index within slot
c_valid  in  1  descriptor valid
c_ready  out  1  descriptor accepted when c_valid&&c_ready
c_chn  in  CH_W  target channel
c_header  in  120  xRAN header, returned on ap_hdr
c_time_offset  in  20  start offset; bits [19:4] compared to din_sample_k
c_num_symbol  in  4  symbols to capture, valid 1..MAX_SYM
ap_req  out  NUM_CH  per-channel buffer-ready request
ap_ack  in  NUM_CH  per-channel release
ap_hdr  out  120*NUM_CH  header of requested bank, channel n at [120n+:120]
ap_bank  out  NUM_CH  bank index of requested buffer
ap_len  out  16*NUM_CH  captured sample count of requested bank
rd_ch  in  CH_W  read channel
rd_bank  in  1  read bank
rd_addr  in  ADDR_W  read word address
rd_en  in  1  read enable
rd_data  out  32  {di,dr}
err_cmd  out  1  one-cycle pulse: descriptor dropped

Behaviour:
- Reset values: c_ready=0, ap_req=0, ap_hdr=0, ap_bank=0, ap_len=0, rd_data=0, err_cmd=0. All FSMs return to IDLE, all banks are freed, and partial captures are discarded. Memory contents are don't-care.
- Per-channel FSM: IDLE -> ARMED -> CAPTURE -> IDLE.
- c_ready is combinational: target channel is IDLE and has a free bank. With c_valid high and c_ready low, the source holds the descriptor.
- On accept, an invalid descriptor (c_num_symbol==0, c_num_symbol>MAX_SYM, or c_chn>=NUM_CH) is dropped. err_cmd pulses 1 cycle later and the FSM stays IDLE. For c_chn>=NUM_CH, c_ready=1 so the descriptor can drain.
- On accept of a valid descriptor, latch header, offset, nsym and target bank (the lowest free bank), then go to ARMED.
- ARMED -> CAPTURE on a cycle with din_valid && din_chn==ch && din_sample_k==offset[19:4]. That sample is written to address 0.
- CAPTURE: every din_valid sample with din_chn==ch writes at address wr_cnt, and wr_cnt increments. Samples of other channels and cycles with din_valid=0 do not advance wr_cnt.
- Capture ends on the write with wr_cnt==SYM_LEN*nsym-1: the bank is marked full, wr_cnt clears, and the FSM returns to IDLE in the same cycle.
- Memory write lands 1 cycle after the input sample, through registered addr, data and enable.
- Full banks queue per channel in fill order. The head of the queue drives ap_req=1 with ap_hdr, ap_bank and ap_len (=SYM_LEN*nsym), registered one cycle after the final write.
- ap_ack while ap_req=1: the next cycle ap_req=0 and the bank is freed. If a second bank is full, it is presented one cycle after that (ap_req low for exactly 1 cycle). ap_ack while ap_req=0 is ignored.
- A descriptor is accepted in the same cycle a bank is freed only from the following cycle; c_ready reflects registered bank state.
- Read: rd_data = mem[rd_ch][rd_bank][rd_addr] 3 cycles after rd_en. rd_data=0 three cycles after a cycle with rd_en=0.
- Reading a bank under capture returns undefined data with no other side effect. rd_addr >= SYM_LEN*MAX_SYM is undefined.
- Channels are fully independent. Simultaneous final writes on different channels each raise their own ap_req in the same cycle.

Test Plan:
- Single occasion: ch1, offset=0x00050, nsym=1, 4 channels interleaved continuously. Capture starts at the ch1 sample with k=5. ap_req[1] rises 1 cycle after the 1536th ch1 sample, with ap_bank[1]=0, ap_len=1536 and ap_hdr equal to c_header. Readback of addrs 0..1535 matches the samples with 3-cycle latency.
- Ping-pong: two descriptors to ch0 with no ack in between; the second uses bank 1, and c_ready stays low for a third until ap_ack[0]. After the ack, ap_req[0] drops for 1 cycle, then presents bank 1 with the second header.
- Gapped input: din_valid toggles 1/0 and other channels interleave. The captured count stays exactly SYM_LEN*nsym, with no duplicated or skipped samples.
- Invalid descriptors: nsym=0, nsym=5, c_chn=7 -> each is accepted, err_cmd pulses once, and no ap_req rises.
- Max-length capture: nsym=4 -> ap_len=6144, and last-address data is correct.
- Reset mid-capture: rst at sample 700 -> ap_req=0 and c_ready=0 during reset. After reset, a fresh descriptor captures normally into bank 0.
